// File: rtl/openframe_pad_ctrl.sv
// openframe_pad_ctrl: per-pad Wishbone-programmable mux between Openframe GPIO pads and SoC core functions.
// Latency: ack/read data one cycle after request; pad outputs combinational; core_in SYNC_STAGES, PEND SYNC_STAGES+1.
// Backpressure: none; every request is acked once and then a forced idle cycle, so a held strobe acks every 2 cycles.
module openframe_pad_ctrl #(
  parameter int          NUM_PADS    = 44,
  parameter int          ADR_W       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [2:0]  DM_RESET    = 3'b110
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [ADR_W-1:0]    wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  input  logic [NUM_PADS-1:0] core_out,
  input  logic [NUM_PADS-1:0] core_oeb,
  output logic [NUM_PADS-1:0] core_in,
  input  logic [NUM_PADS-1:0] gpio_in,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic                irq
);

  // Stored config bits 8:0 map 1:1 onto register bits 8:0 (FALL_EN..SEL).
  localparam logic [8:0] CFG_RESET = {3'b000, DM_RESET, 3'b000};

  logic [NUM_PADS-1:0][8:0]          cfg_q, cfg_d;
  logic [NUM_PADS-1:0]               pend_q, pend_d;
  logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q, sync_d;
  logic [NUM_PADS-1:0]               prev_q, prev_d;
  logic                              ack_q, ack_d;
  logic [31:0]                       dat_q, dat_d;

  logic                              req, wr;
  logic [NUM_PADS-1:0]               hit;
  logic [31:0]                       rdata;

  assign core_in   = sync_q[SYNC_STAGES-1];
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = |pend_q;

  // Next-state: bus handshake, register writes with byte lanes, W1C pending, synchroniser and edge capture.
  always_comb begin
    req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
    wr    = req & wbs_we_i;
    rdata = '0;
    hit   = '0;
    cfg_d = cfg_q;
    pend_d = pend_q;
    for (int n = 0; n < NUM_PADS; n++) begin
      hit[n] = (wbs_adr_i == ADR_W'(n));
      if (hit[n]) rdata = {21'b0, pend_q[n], core_in[n], cfg_q[n]};
      if (wr && hit[n]) begin
        if (wbs_sel_i[0]) cfg_d[n][7:0] = wbs_dat_i[7:0];
        if (wbs_sel_i[1]) cfg_d[n][8]   = wbs_dat_i[8];
      end
      // A new edge in the same cycle as a W1C clear keeps PEND set.
      pend_d[n] = (pend_q[n] & ~(wr & hit[n] & wbs_sel_i[1] & wbs_dat_i[10]))
                | (core_in[n] & ~prev_q[n] & cfg_q[n][7])
                | (~core_in[n] & prev_q[n] & cfg_q[n][8]);
    end
    sync_d[0] = gpio_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d = core_in;
    ack_d  = req;
    dat_d  = req ? rdata : 32'h0;
  end

  // All state with synchronous reset; reset mid-transfer drops the pending ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < NUM_PADS; n++) cfg_q[n] <= CFG_RESET;
      pend_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
    end else begin
      cfg_q  <= cfg_d;
      pend_q <= pend_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  // Pad-facing mux and configuration, combinational from registers and core signals.
  always_comb begin
    for (int n = 0; n < NUM_PADS; n++) begin
      gpio_out[n]     = cfg_q[n][0] ? cfg_q[n][2] : core_out[n];
      gpio_oeb[n]     = cfg_q[n][0] ? ~cfg_q[n][1] : core_oeb[n];
      gpio_dm0[n]     = cfg_q[n][3];
      gpio_dm1[n]     = cfg_q[n][4];
      gpio_dm2[n]     = cfg_q[n][5];
      gpio_inp_dis[n] = cfg_q[n][6];
    end
  end

endmodule

// File: tb/tb_openframe_pad_ctrl.sv
// Directed bench for openframe_pad_ctrl with default parameters (44 pads, 2 sync stages, DM_RESET=110).
module tb_openframe_pad_ctrl;
  localparam int N = 44;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [7:0]    adr;
  logic [31:0]   dat_i, dat_o;
  logic          ack;
  logic [N-1:0]  core_out, core_oeb, core_in, gpio_in;
  logic [N-1:0]  gpio_out, gpio_oeb, dm0, dm1, dm2, inp_dis;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;
  logic [5:0]  ack_pat;

  always #5 clk = ~clk;

  openframe_pad_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .gpio_dm0(dm0), .gpio_dm1(dm1), .gpio_dm2(dm2),
    .gpio_inp_dis(inp_dis), .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone transfer; called just after a rising edge, returns 1 ns after the ack edge.
  task automatic wb(input logic w, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r);
    logic got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    r = 32'h0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1);
      if (ack) begin
        got = 1'b1;
        r = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", {63'b0, got}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 8'h0; dat_i = 32'h0;
    core_out = 44'h0F0_F0F0_F0F0;
    core_oeb = 44'hA5A_5A5A_5A5A;
    gpio_in  = '0;
    step(3);
    chk("rst_ack", {63'b0, ack}, 64'd0);
    chk("rst_dat", {32'b0, dat_o}, 64'd0);
    chk("rst_irq", {63'b0, irq}, 64'd0);
    rst = 1'b0;
    step(1);

    // Reset state
    wb(1'b0, 8'd0, 32'h0, 4'hF, rd);
    chk("rst_read_pad0", {32'b0, rd}, 64'h30);
    chk("rst_oeb", {20'b0, gpio_oeb}, {20'b0, core_oeb});
    chk("rst_out", {20'b0, gpio_out}, {20'b0, core_out});
    chk("rst_dm", {dm2 & dm1 & ~dm0}, {20'b0, {N{1'b1}}});
    chk("rst_inp_dis", {20'b0, inp_dis}, 64'd0);
    step(1);

    // Software mode on pad 5
    wb(1'b1, 8'd5, 32'h0000_0037, 4'b0001, rd);
    chk("sw_out5", {63'b0, gpio_out[5]}, 64'd1);
    chk("sw_oeb5", {63'b0, gpio_oeb[5]}, 64'd0);
    core_out[5] = 1'b0; core_oeb[5] = 1'b1;
    #1;
    chk("sw_out5_hold", {63'b0, gpio_out[5]}, 64'd1);
    chk("sw_oeb5_hold", {63'b0, gpio_oeb[5]}, 64'd0);
    chk("core_out4", {63'b0, gpio_out[4]}, {63'b0, core_out[4]});
    step(1);
    wb(1'b0, 8'd5, 32'h0, 4'hF, rd);
    chk("read_pad5", {32'b0, rd}, 64'h37);
    step(1);

    // Byte lanes: only lane 1 (FALL_EN) lands
    wb(1'b1, 8'd3, 32'hFFFF_FFFF, 4'b0010, rd);
    step(1);
    wb(1'b0, 8'd3, 32'h0, 4'hF, rd);
    chk("lane1_pad3", {32'b0, rd}, 64'h130);
    chk("lane1_oeb3", {63'b0, gpio_oeb[3]}, {63'b0, core_oeb[3]});
    step(1);

    // Rising-edge interrupt on pad 10
    wb(1'b1, 8'd10, 32'h0000_00B0, 4'b0001, rd);
    gpio_in[10] = 1'b1;
    step(1);
    chk("sync1_core_in", {63'b0, core_in[10]}, 64'd0);
    chk("sync1_irq", {63'b0, irq}, 64'd0);
    step(1);
    chk("sync2_core_in", {63'b0, core_in[10]}, 64'd1);
    chk("sync2_irq", {63'b0, irq}, 64'd0);
    step(1);
    chk("edge3_irq", {63'b0, irq}, 64'd1);
    wb(1'b0, 8'd10, 32'h0, 4'hF, rd);
    chk("pend_read10", {32'b0, rd}, 64'h6B0);
    step(1);
    wb(1'b1, 8'd10, 32'h0000_0400, 4'b0010, rd);
    chk("w1c_irq", {63'b0, irq}, 64'd0);
    step(1);
    wb(1'b0, 8'd10, 32'h0, 4'hF, rd);
    chk("w1c_read10", {32'b0, rd}, 64'h2B0);
    gpio_in[10] = 1'b0;
    step(6);
    chk("fall_no_pend", {63'b0, irq}, 64'd0);

    // Set/clear collision: W1C commits on the edge where PEND sets
    gpio_in[10] = 1'b1;
    step(2);
    wb(1'b1, 8'd10, 32'h0000_0400, 4'b0010, rd);
    chk("collide_irq", {63'b0, irq}, 64'd1);
    step(1);
    wb(1'b0, 8'd10, 32'h0, 4'hF, rd);
    chk("collide_read10", {32'b0, rd}, 64'h6B0);
    step(1);
    wb(1'b1, 8'd10, 32'h0000_0400, 4'b0010, rd);
    chk("collide_clear", {63'b0, irq}, 64'd0);

    // Falling-edge interrupt on pad 12 with input disabled
    wb(1'b1, 8'd12, 32'h0000_0170, 4'b0011, rd);
    chk("inp_dis12", {63'b0, inp_dis[12]}, 64'd1);
    gpio_in[12] = 1'b1;
    step(5);
    chk("rise_no_pend12", {63'b0, irq}, 64'd0);
    gpio_in[12] = 1'b0;
    step(5);
    chk("fall_pend12", {63'b0, irq}, 64'd1);
    wb(1'b0, 8'd12, 32'h0, 4'hF, rd);
    chk("read12", {32'b0, rd}, 64'h570);
    step(1);
    wb(1'b1, 8'd12, 32'h0000_0400, 4'b0010, rd);
    chk("clear12", {63'b0, irq}, 64'd0);
    step(1);

    // Out-of-range access
    wb(1'b1, 8'd44, 32'hFFFF_FFFF, 4'hF, rd);
    step(1);
    wb(1'b0, 8'd44, 32'h0, 4'hF, rd);
    chk("oor_read", {32'b0, rd}, 64'd0);
    step(1);
    wb(1'b0, 8'd0, 32'h0, 4'hF, rd);
    chk("oor_no_alias", {32'b0, rd}, 64'h30);
    step(1);

    // Held strobe acks on alternate cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      ack_pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", {58'b0, ack_pat}, 64'h15);
    step(2);

    // Reset mid-transfer
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd0; dat_i = 32'h1; sel = 4'h1;
    rst = 1'b1;
    step(1);
    chk("rst_mid_ack", {63'b0, ack}, 64'd0);
    step(1);
    chk("rst_mid_ack2", {63'b0, ack}, 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    step(1);
    wb(1'b0, 8'd0, 32'h0, 4'hF, rd);
    chk("rst_mid_pad0", {32'b0, rd}, 64'h30);
    step(1);
    wb(1'b0, 8'd5, 32'h0, 4'hF, rd);
    chk("rst_mid_pad5", {32'b0, rd}, 64'h30);
    chk("rst_mid_oeb5", {63'b0, gpio_oeb[5]}, {63'b0, core_oeb[5]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
